arbitro_cruzamento: RTL and testbench
=====================================

// Module: arbitro_cruzamento
// PURPOSE
//   Round-robin phase scheduler for one N_VIAS-approach intersection built from the semaforo light model.
//   Latches vehicle-button requests and grants one approach at a time: GREEN -> YELLOW -> ALL-RED clearance.
//   Only the granted approach is ever non-red; the block is the sole driver of every light vector.
// PARAMETERS
//   N_VIAS      4      number of approaches, legal 2..8
//   T_VERDE     8'd4   cycles in GREEN, legal 1..255
//   T_AMARELO   8'd2   cycles in YELLOW, legal 1..255
//   T_VERMELHO  8'd2   cycles in ALL-RED clearance, legal 1..255
//   T_WALK      8'd3   cycles in WALK (PED_CROSSING_EN only), legal 1..255
// PORTS
//   clk     in   1           single clock, rising edge
//   rst     in   1           synchronous, active-high reset
//   bt      in   N_VIAS      per-approach request pulse/level, bit i = approach i
//   ped_bt  in   1           pedestrian request; present only with PED_CROSSING_EN
//   luz     out  3*N_VIAS    light of approach i at [3i+2:3i]: 001 green, 010 yellow, 100 red
//   grant   out  3           index of approach currently or last served
//   walk    out  1           pedestrian walk lamp; tied 0 without PED_CROSSING_EN
//   busy    out  1           1 while in GREEN, YELLOW or WALK
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=ALLRED, cnt=T_VERMELHO-1, ptr=0, grant=0, pend=0, ped_pend=0,
//     luz = all 100, walk=0, busy=0. rst overrides any state mid-phase; lights go all-red at that edge.
//   Cycle numbering: cycle 1 = first rising edge with rst=0.
//   Timer: 8-bit down counter cnt. On state entry cnt=T_x-1; cnt!=0 -> decrement; cnt==0 -> transition.
//     So each timed state lasts exactly T_x cycles. No wrap: cnt never decrements below 0.
//   Requests: pend[i] set on any edge with bt[i]=1; sticky until served.
//     pend[i] cleared on the edge entering GREEN for i; bt[i]=1 on that edge or during GREEN of i is dropped;
//     bt[i]=1 during YELLOW/ALLRED of i is latched (served next round).
//   States:
//     ALLRED: all lights 100. At cnt==0: if ped_pend -> WALK (macro only);
//       else if pend!=0 -> GREEN, grant = first i with pend[i]=1 searching ptr, ptr+1, ... mod N_VIAS;
//       else remain in ALLRED with cnt=0, re-arbitrating every cycle (pend set at edge k -> GREEN at k+1).
//     GREEN:  luz[grant]=001; at cnt==0 -> YELLOW.
//     YELLOW: luz[grant]=010; at cnt==0 -> ALLRED, cnt=T_VERMELHO-1, ptr=(grant+1) mod N_VIAS.
//   Fairness: a requesting approach waits at most N_VIAS-1 full phases.
//   Outputs are registered; luz/grant/busy change on the same edge as the state.
//   Simultaneous requests: all latched in one cycle, served in round-robin order from ptr.
//   No requests ever: block idles in ALLRED indefinitely, busy=0.
// CONFIGURATION
//   PED_CROSSING_EN defined: ped_bt port exists; ped_pend set by ped_bt, cleared on WALK entry.
//     WALK has priority over vehicle grants at ALLRED exit; all luz=100, walk=1 for T_WALK cycles,
//     then ALLRED (T_VERMELHO) with ptr unchanged. ped_bt during WALK is dropped.
//   PED_CROSSING_EN undefined: no ped_bt port, no WALK state, walk held 0.
// TESTING (defaults; Ln = luz[3n+2:3n])
//   Reset hold 3 cycles, no bt -> luz=12'h924 (all red), busy=0, grant=0 for 20 cycles.
//   bt[2] pulse at cycle 1 -> L2=001 cycles 3-6, 010 cycles 7-8, 100 from 9; L0,L1,L3=100 throughout; grant=2.
//   bt=4'b1011 at cycle 1 -> greens in order 0,1,3, each 4+2+2 cycles apart, never two non-red approaches.
//   bt[1] pulsed during GREEN of 1 -> dropped (no second phase); pulsed during YELLOW of 1 -> one extra phase for 1.
//   rst=1 for one edge during GREEN of approach 0 -> next cycle all red, pend cleared, cnt restarts T_VERMELHO.
//   PED_CROSSING_EN: ped_bt and bt[0] together at cycle 1 -> walk=1 cycles 3-5, ALLRED 6-7, L0=001 cycles 8-11.

Source files
------------

// File: rtl/arbitro_cruzamento.sv
// arbitro_cruzamento: round-robin phase scheduler for an N_VIAS-approach
// intersection. Each served approach runs GREEN -> YELLOW -> ALL-RED, and only
// the granted approach is ever non-red. Requests are latched per approach and
// served in rotating order starting just past the last served approach.
// Optional feature macro: PED_CROSSING_EN adds a ped_bt input and a WALK phase
// (all red, walk lamp on) that takes priority at the exit of ALL-RED.
module arbitro_cruzamento #(
    parameter int         N_VIAS     = 4,
    parameter logic [7:0] T_VERDE    = 8'd4,
    parameter logic [7:0] T_AMARELO  = 8'd2,
    parameter logic [7:0] T_VERMELHO = 8'd2,
    parameter logic [7:0] T_WALK     = 8'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_VIAS-1:0]     bt,
`ifdef PED_CROSSING_EN
    input  logic                  ped_bt,
`endif
    output logic [3*N_VIAS-1:0]   luz,
    output logic [2:0]            grant,
    output logic                  walk,
    output logic                  busy
);

    localparam logic [2:0] C_GREEN  = 3'b001;
    localparam logic [2:0] C_YELLOW = 3'b010;
    localparam logic [2:0] C_RED    = 3'b100;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_WALK   = 2'd3
    } state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [2:0]            ptr_q;
    logic [2:0]            grant_q;
    logic [N_VIAS-1:0]     pend_q;
    logic [N_VIAS-1:0]     pend_d;
    logic [3*N_VIAS-1:0]   luz_q;
    logic                  busy_q;
    logic                  walk_q;

    logic                  ped_req;
    logic                  arb_found;
    logic [2:0]            arb_idx;
    logic [3:0]            arb_try;
    logic [7:0]            pend_wide;
    logic                  go_green;
    logic                  clr_en;
    logic [2:0]            clr_idx;

    // One approach shows the given colour, every other approach shows red.
    function automatic logic [3*N_VIAS-1:0] lights(input logic [2:0] color,
                                                   input logic [2:0] idx);
        logic [3*N_VIAS-1:0] v;
        for (int i = 0; i < N_VIAS; i++) begin
            v[3*i +: 3] = (3'(i) == idx) ? color : C_RED;
        end
        return v;
    endfunction

`ifdef PED_CROSSING_EN
    logic ped_pend_q;
    logic ped_pend_d;

    assign ped_req = ped_pend_q;

    // Pedestrian request is dropped while walking and consumed on WALK entry.
    always_comb begin
        ped_pend_d = ped_pend_q | ped_bt;
        if (state_q == ST_WALK || (state_q == ST_ALLRED && cnt_q == 8'd0 && ped_pend_q)) begin
            ped_pend_d = 1'b0;
        end
    end

    // Pedestrian request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end
`else
    assign ped_req = 1'b0;
`endif

    // Round-robin search: the pending approach closest to ptr (going upward) wins.
    // The loop runs from the farthest offset down so the nearest one is kept.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_try   = 4'd0;
        pend_wide = 8'(pend_q);
        for (int k = N_VIAS - 1; k >= 0; k--) begin
            arb_try = {1'b0, ptr_q} + 4'(k);
            if (arb_try >= 4'(N_VIAS)) begin
                arb_try = arb_try - 4'(N_VIAS);
            end
            if (pend_wide[arb_try[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_try[2:0];
            end
        end
    end

    assign go_green = (state_q == ST_ALLRED) && (cnt_q == 8'd0) && !ped_req && arb_found;

    // Which request bit is being served (and therefore cleared) on this edge.
    always_comb begin
        clr_en  = 1'b0;
        clr_idx = grant_q;
        if (state_q == ST_GREEN) begin
            clr_en = 1'b1;
        end else if (go_green) begin
            clr_en  = 1'b1;
            clr_idx = arb_idx;
        end
    end

    // Per-approach sticky request: set by bt, cleared on entry to / during its GREEN.
    for (genvar gi = 0; gi < N_VIAS; gi++) begin : g_pend
        assign pend_d[gi] = (pend_q[gi] | bt[gi]) & ~(clr_en && (clr_idx == 3'(gi)));
    end

    // Phase sequencer with registered light, grant, busy and walk outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ALLRED;
            cnt_q   <= T_VERMELHO - 8'd1;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            pend_q  <= '0;
            luz_q   <= lights(C_RED, 3'd0);
            busy_q  <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                ST_ALLRED: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (ped_req) begin
                        state_q <= ST_WALK;
                        cnt_q   <= T_WALK - 8'd1;
                        walk_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (arb_found) begin
                        state_q <= ST_GREEN;
                        cnt_q   <= T_VERDE - 8'd1;
                        grant_q <= arb_idx;
                        luz_q   <= lights(C_GREEN, arb_idx);
                        busy_q  <= 1'b1;
                    end
                end
                ST_GREEN: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= ST_YELLOW;
                        cnt_q   <= T_AMARELO - 8'd1;
                        luz_q   <= lights(C_YELLOW, grant_q);
                    end
                end
                ST_YELLOW: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= ST_ALLRED;
                        cnt_q   <= T_VERMELHO - 8'd1;
                        ptr_q   <= (grant_q == 3'(N_VIAS - 1)) ? 3'd0 : grant_q + 3'd1;
                        luz_q   <= lights(C_RED, 3'd0);
                        busy_q  <= 1'b0;
                    end
                end
                ST_WALK: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= ST_ALLRED;
                        cnt_q   <= T_VERMELHO - 8'd1;
                        walk_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ALLRED;
                    cnt_q   <= T_VERMELHO - 8'd1;
                    luz_q   <= lights(C_RED, 3'd0);
                    busy_q  <= 1'b0;
                    walk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign luz   = luz_q;
    assign grant = grant_q;
    assign busy  = busy_q;
    assign walk  = walk_q;

endmodule

// File: tb/tb_arbitro_cruzamento.sv
// Directed bench for arbitro_cruzamento (default parameters). "Cycle n" is the
// output value seen between rising edge n-1 and rising edge n, where edge 1 is
// the first edge with rst low; inputs set at cycle n are sampled by edge n.
module tb_arbitro_cruzamento;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  bt  = 4'd0;
`ifdef PED_CROSSING_EN
    logic        ped_bt = 1'b0;
`endif
    logic [11:0] luz;
    logic [2:0]  grant;
    logic        walk;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Test plan: phases (start cycle of GREEN, approach), bt pulses, reset, walk.
    int          ph_start [4];
    int          ph_app   [4];
    int          ph_n;
    int          st_cyc   [6];
    logic [3:0]  st_val   [6];
    int          st_n;
    int          rst_at;
    int          wk_start;
    int          ped_at;

    always #5 clk = ~clk;

    arbitro_cruzamento dut (
        .clk    (clk),
        .rst    (rst),
        .bt     (bt),
`ifdef PED_CROSSING_EN
        .ped_bt (ped_bt),
`endif
        .luz    (luz),
        .grant  (grant),
        .walk   (walk),
        .busy   (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_plan();
        ph_n = 0; st_n = 0; rst_at = -1; wk_start = -1; ped_at = -1;
    endtask

    task automatic add_phase(input int s, input int a);
        ph_start[ph_n] = s; ph_app[ph_n] = a; ph_n++;
    endtask

    task automatic add_stim(input int c, input logic [3:0] v);
        st_cyc[st_n] = c; st_val[st_n] = v; st_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bt  = 4'd0;
`ifdef PED_CROSSING_EN
        ped_bt = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
    endtask

    // Walk cycles 1..last: check outputs against the plan, then drive the plan's inputs.
    task automatic run(input string name, input int last);
        logic [11:0] e_luz;
        logic [2:0]  e_grant;
        logic        e_busy;
        logic        e_walk;
        int          last_ev;
        int          t;
        bit          dead;
        while (cyc <= last) begin
            e_luz   = 12'h924;
            e_grant = 3'd0;
            e_busy  = 1'b0;
            e_walk  = 1'b0;
            last_ev = -1;
            for (int p = 0; p < ph_n; p++) begin
                t    = cyc - ph_start[p];
                dead = (rst_at >= 0) && (ph_start[p] <= rst_at) && (cyc > rst_at);
                if (t >= 0 && t < 6 && !dead) begin
                    e_luz[3*ph_app[p] +: 3] = (t < 4) ? 3'b001 : 3'b010;
                    e_busy = 1'b1;
                end
                if (t >= 0 && ph_start[p] > last_ev) begin
                    last_ev = ph_start[p];
                    e_grant = 3'(ph_app[p]);
                end
            end
            if (rst_at >= 0 && cyc > rst_at && rst_at + 1 > last_ev) begin
                e_grant = 3'd0;
            end
            if (wk_start >= 0 && cyc >= wk_start && cyc < wk_start + 3) begin
                e_walk = 1'b1;
                e_busy = 1'b1;
            end
            check_val({name, ".luz"},   32'(luz),   32'(e_luz));
            check_val({name, ".grant"}, 32'(grant), 32'(e_grant));
            check_val({name, ".busy"},  32'(busy),  32'(e_busy));
            check_val({name, ".walk"},  32'(walk),  32'(e_walk));
            bt = 4'd0;
            for (int s = 0; s < st_n; s++) begin
                if (st_cyc[s] == cyc) bt = bt | st_val[s];
            end
            rst = (cyc == rst_at);
`ifdef PED_CROSSING_EN
            ped_bt = (cyc == ped_at);
`endif
            @(negedge clk);
            cyc++;
        end
        bt  = 4'd0;
        rst = 1'b0;
`ifdef PED_CROSSING_EN
        ped_bt = 1'b0;
`endif
    endtask

    initial begin
        // No requests: all red, idle, grant 0.
        do_reset(); clear_plan();
        run("idle", 20);

        // Single request on approach 2.
        do_reset(); clear_plan();
        add_stim(1, 4'b0100); add_phase(3, 2);
        run("single", 14);

        // Simultaneous requests 0,1,3 served in round-robin order.
        do_reset(); clear_plan();
        add_stim(1, 4'b1011); add_phase(3, 0); add_phase(11, 1); add_phase(19, 3);
        run("multi", 30);

        // Requests on the GREEN entry edge and during GREEN of 1 are dropped.
        do_reset(); clear_plan();
        add_stim(1, 4'b0010); add_stim(2, 4'b0010); add_stim(4, 4'b0010); add_phase(3, 1);
        run("drop", 18);

        // Request during YELLOW of 1 earns one extra phase.
        do_reset(); clear_plan();
        add_stim(1, 4'b0010); add_stim(7, 4'b0010); add_phase(3, 1); add_phase(11, 1);
        run("latch", 22);

        // Reset during GREEN of 0: all red, pending 2 forgotten, timer restarts.
        do_reset(); clear_plan();
        add_stim(1, 4'b0101); add_stim(5, 4'b1000); rst_at = 4;
        add_phase(3, 0); add_phase(7, 3);
        run("midrst", 24);

        // Late request while idling in ALL-RED: GREEN one edge after latching.
        do_reset(); clear_plan();
        add_stim(10, 4'b1000); add_phase(12, 3);
        run("late", 22);

        // Pointer continues past last served approach (1): 2 before 0.
        do_reset(); clear_plan();
        add_stim(1, 4'b0010); add_stim(5, 4'b0101);
        add_phase(3, 1); add_phase(11, 2); add_phase(19, 0);
        run("ptr", 30);

`ifdef PED_CROSSING_EN
        // Pedestrian has priority: WALK 3-5, ALL-RED 6-7, approach 0 green 8-11.
        do_reset(); clear_plan();
        add_stim(1, 4'b0001); ped_at = 1; wk_start = 3; add_phase(8, 0);
        run("ped", 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
